cmem_mp: RTL and testbench
==========================

Name: cmem_mp

Overview:
Parametrised multi-read-port coefficient memory; the successor to the single-read-port 256x20 cmem. It has a host write port with active-low CEN/WEN like cmem and NRD independent registered read ports. It also has a streaming bulk-load engine with a valid/ready handshake and auto-incrementing address, plus a hardware zero-initialisation sweep after reset. It sits between the coefficient loader and the datapath lanes, which read coefficients in parallel.

Parameters:
DW, 20, data word width
AW, 8, address width; DEPTH = 2**AW words
NRD, 2, number of read ports (1..8)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
CEN  in  1  active-low chip enable (gates host write and all reads)
WEN  in  1  active-low host write enable
CADDR  in  AW  host write address
D  in  DW  host write data
A  in  NRD*AW  read addresses; port k uses A[k*AW +: AW]
Q  out  NRD*DW  registered read data; port k uses Q[k*DW +: DW]
ld_start  in  1  one-cycle pulse; starts a bulk load
ld_base  in  AW  bulk-load start address, sampled on ld_start
ld_len  in  AW+1  bulk-load word count (0..DEPTH), sampled on ld_start
ld_valid  in  1  load data valid
ld_data  in  DW  load data
ld_ready  out  1  load engine accepts a beat
ld_done  out  1  one-cycle pulse when a load completes
busy  out  1  high in INIT or LOAD
init_done  out  1  high once the zero sweep has finished; stays high until next reset

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to INIT, init counter clears to 0.
  - Q=0, ld_ready=0, ld_done=0, init_done=0, busy=1.
  - Memory contents are not reset directly.
- FSM states: INIT, IDLE, LOAD.
- INIT:
  - Writes 0 to address cnt each cycle; cnt runs 0..DEPTH-1.
  - After the write to DEPTH-1, goes to IDLE. init_done=1 and busy=0 from the next cycle on.
  - The sweep takes exactly DEPTH cycles after rst_n rises.
  - Host writes and ld_start are ignored; Q is held at 0.
- IDLE:
  - Host write when CEN=0 and WEN=0: mem[CADDR] <= D.
  - ld_start with ld_len != 0: latch ptr=ld_base and remaining=ld_len, go to LOAD.
  - ld_start with ld_len == 0: ld_done pulses the next cycle; FSM stays in IDLE.
- LOAD:
  - ld_ready=1 and busy=1.
  - Each cycle with ld_valid=1: mem[ptr] <= ld_data; ptr <= ptr+1 mod DEPTH (wraps from DEPTH-1 to 0); remaining decrements.
  - When the last beat is accepted: ld_ready drops and ld_done pulses the next cycle; FSM returns to IDLE.
  - ld_valid=0 stalls the load without losing state.
  - Host writes are ignored in LOAD; the load engine has priority.
  - ld_start is ignored while busy.
- Reads (IDLE and LOAD):
  - If CEN=0, Q_k <= mem[A_k] on posedge; latency is 1 cycle.
  - If CEN=1, Q holds its value.
  - Ports are independent; any ports may read the same address.
- Write-through: a read to an address written in the same cycle (host or load) returns the NEW data.
- Reset asserted mid-load or mid-sweep aborts immediately.
  - No ld_done is issued.
  - The sweep restarts from 0 and zeroes the whole memory again.
- Unknown or undriven (Z) CADDR/D with WEN=1 must not corrupt memory.

Optional Feature:
CMEM_PARITY_EN: when defined, each word stores an extra even-parity bit.
- New ports: perr_inj in 1 (inverts the stored parity bit on any write that cycle); par_err out NRD (registered alongside Q; bit k=1 if the word read by port k fails parity).
- The INIT sweep writes correct parity; par_err resets to 0 and holds when CEN=1.
When not defined: no parity storage, and neither perr_inj nor par_err exists.

Test Plan:
- Release rst_n, DW=20, AW=8: busy=1 for exactly 256 cycles; then init_done=1, and every address reads 0 on all ports.
- Host write 0xABCDE to addr 5, then 0x12345 to addr 6; read A0=5, A1=6 -> Q0=0xABCDE, Q1=0x12345 one cycle later. CEN=1 next cycle -> Q holds.
- Bulk load ld_base=254, ld_len=4, data 1,2,3,4 with ld_valid low for 2 cycles between beats 2 and 3 -> addresses 254,255,0,1 hold 1,2,3,4; ld_done is a single pulse after beat 4.
- Same-cycle host write of 0x00FF0 to addr 10 while port 1 reads addr 10 -> Q1=0x00FF0; a host write during LOAD leaves memory unchanged.
- Assert rst_n=0 after 2 of 8 load beats -> no ld_done; after the 256-cycle sweep the loaded addresses read 0.
- (CMEM_PARITY_EN) Write addr 3 with perr_inj=1, read on port 0 -> par_err[0]=1. Rewrite with perr_inj=0 -> par_err[0]=0.

Source files
------------

// File: rtl/cmem_mp.sv
// cmem_mp: multi-read-port coefficient memory, DEPTH = 2**AW words of DW bits.
//
// A host write port (active-low CEN/WEN), NRD independent registered read
// ports, a streaming bulk-load engine (valid/ready, auto-incrementing address
// that wraps at DEPTH) and a zero-fill sweep that runs after every reset.
// Reads see a same-cycle write (host or load) as the new data.
//
// Ports:
//   clk, rst_n          clock (posedge) and synchronous active-low reset
//   CEN, WEN            active-low chip enable (host write + all reads) / write enable
//   CADDR, D            host write address / data
//   A, Q                packed read addresses / registered read data, port k at slice k
//   ld_start            one-cycle pulse, samples ld_base and ld_len
//   ld_base, ld_len     load start address / word count (0..DEPTH)
//   ld_valid, ld_data   load beat handshake and data
//   ld_ready            engine accepts a beat this cycle
//   ld_done             one-cycle pulse after the last beat (or a zero-length start)
//   busy                high while sweeping or loading
//   init_done           high once the zero-fill sweep has completed
//
// Optional build macro CMEM_PARITY_EN adds an even-parity bit per word:
//   perr_inj            inverts the stored parity bit of any host/load write that cycle
//   par_err[k]          registered with Q; set when port k's word fails parity
module cmem_mp #(
  parameter int DW  = 20,
  parameter int AW  = 8,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [AW-1:0]     CADDR,
  input  logic [DW-1:0]     D,
  input  logic [NRD*AW-1:0] A,
  output logic [NRD*DW-1:0] Q,
  input  logic              ld_start,
  input  logic [AW-1:0]     ld_base,
  input  logic [AW:0]       ld_len,
  input  logic              ld_valid,
  input  logic [DW-1:0]     ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy,
  output logic              init_done
`ifdef CMEM_PARITY_EN
  ,
  input  logic              perr_inj,
  output logic [NRD-1:0]    par_err
`endif
);

  localparam int DEPTH = 2**AW;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   cnt;        // sweep address
  logic [AW-1:0]   ptr;        // load address
  logic [AW:0]     remaining;  // load beats still expected
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            done_nx;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_data [NRD];

  // Next state, the single write port mux and the handshake outputs.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_nx = state;
    we       = 1'b0;
    waddr    = cnt;
    wdata    = '0;
    done_nx  = 1'b0;
    ld_ready = 1'b0;
    busy     = 1'b1;
    case (state)
      S_INIT: begin
        we = 1'b1;
        if (cnt == '1) state_nx = S_IDLE;
      end
      S_IDLE: begin
        busy = 1'b0;
        // Written as an explicit compare so an unknown WEN never enables a write.
        if (CEN == 1'b0 && WEN == 1'b0) begin
          we    = 1'b1;
          waddr = CADDR;
          wdata = D;
        end
        if (ld_start) begin
          if (ld_len == '0) done_nx  = 1'b1;
          else              state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          we    = 1'b1;
          waddr = ptr;
          wdata = ld_data;
          if (remaining == (AW+1)'(1)) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_INIT;
      cnt       <= '0;
      ld_done   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state   <= state_nx;
      ld_done <= done_nx;
      if (state == S_INIT) cnt <= cnt + 1'b1;
      if (state == S_INIT && state_nx == S_IDLE) init_done <= 1'b1;
      if (state == S_IDLE && ld_start && ld_len != '0) begin
        ptr       <= ld_base;
        remaining <= ld_len;
      end
      if (state == S_LOAD && ld_valid) begin
        ptr       <= ptr + 1'b1;  // wraps naturally at DEPTH
        remaining <= remaining - 1'b1;
      end
    end
  end

  // NOTE: the array has no reset; clearing it is the job of the INIT sweep,
  // which keeps the storage a plain RAM. Writes are blocked while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && we) mem[waddr] <= wdata;
  end

  // Read data with write-through of a same-cycle write.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_data[k] = (we && waddr == A[k*AW +: AW]) ? wdata : mem[A[k*AW +: AW]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Q <= '0;
    end else if (state != S_INIT && !CEN) begin
      for (int k = 0; k < NRD; k++) Q[k*DW +: DW] <= rd_data[k];
    end
  end

`ifdef CMEM_PARITY_EN
  logic            mem_par [DEPTH];
  logic            wpar;
  logic [NRD-1:0]  rd_par;

  // The sweep always stores correct parity; injection only affects real writes.
  assign wpar = (^wdata) ^ (perr_inj && state != S_INIT);

  always_ff @(posedge clk) begin
    if (rst_n && we) mem_par[waddr] <= wpar;
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_par[k] = (we && waddr == A[k*AW +: AW]) ? wpar : mem_par[A[k*AW +: AW]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err <= '0;
    end else if (state != S_INIT && !CEN) begin
      for (int k = 0; k < NRD; k++) par_err[k] <= rd_par[k] ^ (^rd_data[k]);
    end
  end
`endif

endmodule

// File: tb/tb_cmem_mp.sv
// Self-checking bench for cmem_mp (DW=20, AW=8, NRD=2).
// A behavioural model (array + sweep/load counters) predicts every output each
// cycle; a negedge process compares. Directed sequences add literal checks.
module tb_cmem_mp;
  localparam int DW    = 20;
  localparam int AW    = 8;
  localparam int NRD   = 2;
  localparam int DEPTH = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              CEN, WEN;
  logic [AW-1:0]     CADDR;
  logic [DW-1:0]     D;
  logic [NRD*AW-1:0] A;
  logic [NRD*DW-1:0] Q;
  logic              ld_start;
  logic [AW-1:0]     ld_base;
  logic [AW:0]       ld_len;
  logic              ld_valid;
  logic [DW-1:0]     ld_data;
  logic              ld_ready, ld_done, busy, init_done;
  logic              perr_inj;
`ifdef CMEM_PARITY_EN
  logic [NRD-1:0]    par_err;
`endif

  cmem_mp #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .CADDR(CADDR), .D(D),
    .A(A), .Q(Q), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .busy(busy), .init_done(init_done)
`ifdef CMEM_PARITY_EN
    , .perr_inj(perr_inj), .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0]     mm [DEPTH];
  bit                mbad [DEPTH];
  int                sweep_left;
  int                load_left;
  logic [AW-1:0]     load_ptr;
  logic [NRD*DW-1:0] exp_q;
  logic [NRD-1:0]    exp_perr;
  bit                exp_done, exp_init_done;
  bit                mw, mwbad;
  int                mwa;
  logic [DW-1:0]     mwd;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; mbad[i] = 1'b0; end
    sweep_left = DEPTH; load_left = 0; exp_q = '0; exp_perr = '0;
    exp_done = 1'b0; exp_init_done = 1'b0; load_ptr = '0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      sweep_left = DEPTH; load_left = 0; exp_q = '0; exp_perr = '0;
      exp_done = 1'b0; exp_init_done = 1'b0;
    end else begin
      mw = 1'b0; mwbad = 1'b0; mwa = 0; mwd = '0; exp_done = 1'b0;
      if (sweep_left > 0) begin
        mw = 1'b1; mwa = DEPTH - sweep_left;
      end else if (load_left > 0) begin
        if (ld_valid) begin mw = 1'b1; mwa = int'(load_ptr); mwd = ld_data; mwbad = perr_inj; end
      end else if (CEN === 1'b0 && WEN === 1'b0) begin
        mw = 1'b1; mwa = int'(CADDR); mwd = D; mwbad = perr_inj;
      end
      if (mw) begin mm[mwa] = mwd; mbad[mwa] = mwbad; end
      if (sweep_left == 0 && CEN === 1'b0) begin
        for (int k = 0; k < NRD; k++) begin
          exp_q[k*DW +: DW] = mm[A[k*AW +: AW]];
          exp_perr[k]       = mbad[A[k*AW +: AW]];
        end
      end
      if (sweep_left > 0) begin
        sweep_left--;
        if (sweep_left == 0) exp_init_done = 1'b1;
      end else if (load_left > 0) begin
        if (ld_valid) begin
          load_ptr++;
          load_left--;
          if (load_left == 0) exp_done = 1'b1;
        end
      end else if (ld_start) begin
        if (ld_len == '0) exp_done = 1'b1;
        else begin load_left = int'(ld_len); load_ptr = ld_base; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("q", Q, exp_q);
      check("busy", busy, (sweep_left > 0 || load_left > 0));
      check("ld_ready", ld_ready, (sweep_left == 0 && load_left > 0));
      check("ld_done", ld_done, exp_done);
      check("init_done", init_done, exp_init_done);
`ifdef CMEM_PARITY_EN
      check("par_err", par_err, exp_perr);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after rst_n rises; counts cycles with busy high.
  task automatic wait_init();
    int c;
    c = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      c++;
    end
    check("busy_cycles", c, 256);
    check("init_done_lit", init_done, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; CEN = 1'b1; WEN = 1'b1; CADDR = '0; D = '0; A = '0;
    ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    perr_inj = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_q", Q, 0);
    check("reset_busy", busy, 1);
    rst_n = 1'b1;
    wait_init();

    // Every address reads zero on both ports.
    CEN = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      A = {8'(255 - a), 8'(a)};
      tick();
    end
    check("sweep_zero_lit", Q, 0);

    // Host writes then parallel read; CEN=1 holds Q.
    WEN = 1'b0; CADDR = 8'd5; D = 20'hABCDE; tick();
    CADDR = 8'd6; D = 20'h12345; tick();
    WEN = 1'b1; A = {8'd6, 8'd5}; tick();
    check("host_q0", Q[19:0], 20'hABCDE);
    check("host_q1", Q[39:20], 20'h12345);
    CEN = 1'b1; A = '0; tick();
    check("hold_q0", Q[19:0], 20'hABCDE);
    check("hold_q1", Q[39:20], 20'h12345);

    // Same-cycle write-through.
    CEN = 1'b0; WEN = 1'b0; CADDR = 8'd10; D = 20'h00FF0; A = {8'd10, 8'd0}; tick();
    check("wt_q1", Q[39:20], 20'h00FF0);
    WEN = 1'b1;

    // Bulk load with wrap and a 2-cycle stall; host write during the stall.
    ld_base = 8'd254; ld_len = 9'd4; ld_start = 1'b1; tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 20'd1; tick();
    ld_data = 20'd2; tick();
    ld_valid = 1'b0; WEN = 1'b0; CADDR = 8'd20; D = 20'h55555; tick(); tick();
    WEN = 1'b1;
    ld_valid = 1'b1; ld_data = 20'd3; tick();
    ld_data = 20'd4; tick();
    ld_valid = 1'b0;
    check("ld_done_pulse", ld_done, 1);
    check("ld_ready_drop", ld_ready, 0);
    A = {8'd255, 8'd254}; tick();
    check("ld_done_single", ld_done, 0);
    check("ld_254", Q[19:0], 20'd1);
    check("ld_255", Q[39:20], 20'd2);
    A = {8'd1, 8'd0}; tick();
    check("ld_0", Q[19:0], 20'd3);
    check("ld_1", Q[39:20], 20'd4);
    A = {8'd20, 8'd20}; tick();
    check("host_during_load", Q[19:0], 20'd0);

    // Zero-length load: immediate done, no busy.
    ld_len = '0; ld_start = 1'b1; tick();
    ld_start = 1'b0;
    check("zero_len_done", ld_done, 1);
    check("zero_len_busy", busy, 0);
    tick();

    // Unknown address/data with WEN=1 must not write.
    CADDR = 'x; D = 'x; WEN = 1'b1; A = {8'd10, 8'd5}; tick(); tick();
    CADDR = '0; D = '0;
    check("x_q0", Q[19:0], 20'hABCDE);
    check("x_q1", Q[39:20], 20'h00FF0);

    // Full-depth load from base 0.
    ld_base = 8'd0; ld_len = 9'd256; ld_start = 1'b1; tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_data = 20'(i * 3 + 7);
      tick();
    end
    ld_valid = 1'b0;
    check("full_done", ld_done, 1);
    A = {8'd255, 8'd128}; tick();
    check("full_128", Q[19:0], 20'(128 * 3 + 7));
    check("full_255", Q[39:20], 20'(255 * 3 + 7));

    // Reset after 2 of 8 beats: no done, memory re-zeroed.
    ld_base = 8'd100; ld_len = 9'd8; ld_start = 1'b1; tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 20'h11; tick();
    ld_data = 20'h22; tick();
    ld_valid = 1'b0; rst_n = 1'b0; tick();
    check("abort_no_done", ld_done, 0);
    rst_n = 1'b1;
    wait_init();
    A = {8'd101, 8'd100}; tick();
    check("abort_zero", Q, 0);

`ifdef CMEM_PARITY_EN
    WEN = 1'b0; CADDR = 8'd3; D = 20'h00007; perr_inj = 1'b1; tick();
    WEN = 1'b1; perr_inj = 1'b0; A = {8'd0, 8'd3}; tick();
    check("perr_set", par_err[0], 1);
    WEN = 1'b0; D = 20'h00007; tick();
    WEN = 1'b1; tick();
    check("perr_clr", par_err[0], 0);
`endif

    CEN = 1'b1; tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
